fp_adder_stage2: RTL and testbench



---
 rtl/fp_adder_pkg.sv | 17 +
 rtl/fp_mag_recover.sv | 31 +++
 rtl/fp_adder_stage2.sv | 151 +++++++++++++++
 tb/tb_fp_adder_stage2.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_adder_pkg.sv
// Shared widths, constants and state encoding for the single-precision adder.
package fp_adder_pkg;

  localparam int DEF_FP_SIZE   = 32;
  localparam int DEF_FRAC_SIZE = 23;
  localparam int EXP_W         = DEF_FP_SIZE - DEF_FRAC_SIZE - 1;

  localparam logic [EXP_W-1:0]       EXP_MAX = '1;
  localparam logic [DEF_FP_SIZE-1:0] QNAN    = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NORM = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/fp_mag_recover.sv
// Recovers the aligned second significand and forms the unsigned magnitude
// of the significand sum or difference (one extra bit for the carry).
module fp_mag_recover
  import fp_adder_pkg::*;
#(
  parameter int FRAC_SIZE = DEF_FRAC_SIZE
) (
  input  logic [FRAC_SIZE:0]   significand_1,
  input  logic [FRAC_SIZE:0]   shifted_significand_2,
  input  logic                 eff_sub,
  output logic [FRAC_SIZE+1:0] mant
);

  logic [FRAC_SIZE:0] m2;

  // Stage1 hands over the negated operand when signs differ; undo that here.
  // NOTE: every output of a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old one.
  always_comb begin
    m2   = eff_sub ? -shifted_significand_2 : shifted_significand_2;
    mant = '0;
    if (!eff_sub) begin
      mant = {1'b0, significand_1} + {1'b0, m2};
    end else if (significand_1 >= m2) begin
      mant = {1'b0, significand_1 - m2};
    end else begin
      mant = {1'b0, m2 - significand_1};
    end
  end

endmodule

// File: rtl/fp_adder_stage2.sv
// Adder stage 2: significand add/sub, one-bit-per-cycle normalization,
// IEEE-754 packing, and a single-entry output held under backpressure.
module fp_adder_stage2
  import fp_adder_pkg::*;
#(
  parameter int FP_SIZE   = DEF_FP_SIZE,
  parameter int FRAC_SIZE = DEF_FRAC_SIZE
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [FRAC_SIZE:0]               significand_1,
  input  logic [FRAC_SIZE:0]               shifted_significand_2,
  input  logic [FP_SIZE-FRAC_SIZE-2:0]     exponent_1,
  input  logic                             sign_bit,
  input  logic [FP_SIZE-1:0]               num_1,
  input  logic [FP_SIZE-1:0]               num_2,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [FP_SIZE-1:0]               result,
  output logic                             overflow,
  output logic                             zero
);

  localparam int EXP_BITS = FP_SIZE - FRAC_SIZE - 1;
  localparam logic [EXP_BITS:0]  E_ONE  = (EXP_BITS + 1)'(1);
  localparam logic [EXP_BITS:0]  E_ONES = {1'b0, {EXP_BITS{1'b1}}};
  localparam logic [FP_SIZE-1:0] QNAN_W =
    {1'b0, {EXP_BITS{1'b1}}, 1'b1, {(FRAC_SIZE-1){1'b0}}};

  state_t                state_q, state_d;
  logic [FRAC_SIZE+1:0]  mant_q, mant_d, mant_in;
  logic [EXP_BITS:0]     e_q, e_d, e_inc;
  logic                  sign_q, sign_d;
  logic                  special_q, special_d;
  logic [FP_SIZE-1:0]    num_1_q, num_1_d, num_2_q, num_2_d;
  logic [FP_SIZE-1:0]    result_d;
  logic                  overflow_d, zero_d;
  logic                  eff_sub_in, eff_sub_q;
  logic                  num_1_inf, num_2_inf;
  logic [EXP_BITS-1:0]   exp_field;

  assign eff_sub_in = num_1[FP_SIZE-1] ^ num_2[FP_SIZE-1];
  assign eff_sub_q  = num_1_q[FP_SIZE-1] ^ num_2_q[FP_SIZE-1];
  assign num_1_inf  = (&num_1_q[FP_SIZE-2:FRAC_SIZE]) && !(|num_1_q[FRAC_SIZE-1:0]);
  assign num_2_inf  = (&num_2_q[FP_SIZE-2:FRAC_SIZE]) && !(|num_2_q[FRAC_SIZE-1:0]);
  assign e_inc      = e_q + E_ONE;
  assign exp_field  = mant_q[FRAC_SIZE] ? e_q[EXP_BITS-1:0] : '0;

  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);

  fp_mag_recover #(.FRAC_SIZE(FRAC_SIZE)) u_mag_recover (
    .significand_1         (significand_1),
    .shifted_significand_2 (shifted_significand_2),
    .eff_sub               (eff_sub_in),
    .mant                  (mant_in)
  );

  always_comb begin
    state_d    = state_q;
    mant_d     = mant_q;
    e_d        = e_q;
    sign_d     = sign_q;
    special_d  = special_q;
    num_1_d    = num_1_q;
    num_2_d    = num_2_q;
    result_d   = result;
    overflow_d = overflow;
    zero_d     = zero;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          mant_d    = mant_in;
          // Denormals share the minimum normal exponent.
          e_d       = (exponent_1 == '0) ? E_ONE : {1'b0, exponent_1};
          sign_d    = sign_bit;
          special_d = &exponent_1;
          num_1_d   = num_1;
          num_2_d   = num_2;
          state_d   = NORM;
        end
      end

      NORM: begin
        state_d    = DONE;
        overflow_d = 1'b0;
        zero_d     = 1'b0;
        if (special_q) begin
          result_d = (num_1_inf && num_2_inf && eff_sub_q) ? QNAN_W : num_1_q;
        end else if (mant_q[FRAC_SIZE+1]) begin
          if (e_inc == E_ONES) begin
            result_d   = {sign_q, {EXP_BITS{1'b1}}, {FRAC_SIZE{1'b0}}};
            overflow_d = 1'b1;
          end else begin
            result_d = {sign_q, e_inc[EXP_BITS-1:0], mant_q[FRAC_SIZE:1]};
          end
        end else if (mant_q == '0) begin
          // Exact cancellation gives +0; same-sign zeros keep their sign.
          result_d = {~eff_sub_q & sign_q, {(FP_SIZE-1){1'b0}}};
          zero_d   = 1'b1;
        end else if (mant_q[FRAC_SIZE] || (e_q == E_ONE)) begin
          result_d = {sign_q, exp_field, mant_q[FRAC_SIZE-1:0]};
        end else begin
          mant_d  = mant_q << 1;
          e_d     = e_q - E_ONE;
          state_d = NORM;
        end
      end

      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      mant_q    <= '0;
      e_q       <= '0;
      sign_q    <= 1'b0;
      special_q <= 1'b0;
      num_1_q   <= '0;
      num_2_q   <= '0;
      result    <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b0;
    end else begin
      state_q   <= state_d;
      mant_q    <= mant_d;
      e_q       <= e_d;
      sign_q    <= sign_d;
      special_q <= special_d;
      num_1_q   <= num_1_d;
      num_2_q   <= num_2_d;
      result    <= result_d;
      overflow  <= overflow_d;
      zero      <= zero_d;
    end
  end

endmodule

// File: tb/tb_fp_adder_stage2.sv
// Scoreboard bench for fp_adder_stage2: directed corner cases, backpressure,
// mid-operation reset, randomized traffic, and standalone magnitude recovery.
module tb_fp_adder_stage2;

  typedef struct {
    logic [23:0] sig1;
    logic [23:0] sh2;
    logic [7:0]  exp1;
    logic        sign;
    logic [31:0] num_1;
    logic [31:0] num_2;
  } op_t;

  typedef struct {
    logic [31:0] res;
    logic        ovf;
    logic        zro;
    int          acc;
    int          lat;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] significand_1 = '0;
  logic [23:0] shifted_significand_2 = '0;
  logic [7:0]  exponent_1 = '0;
  logic        sign_bit = 1'b0;
  logic [31:0] num_1 = '0;
  logic [31:0] num_2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] result;
  logic        overflow;
  logic        zero;

  logic [23:0] tm_sig1 = '0;
  logic [23:0] tm_sh2 = '0;
  logic        tm_sub = 1'b0;
  logic [24:0] tm_mant;

  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  bit   bp_rand = 1'b0;
  bit   ready_force = 1'b0;
  bit   prev_valid = 1'b0;
  exp_t sb[$];

  fp_adder_stage2 dut (
    .clk                   (clk),
    .rst_n                 (rst_n),
    .in_valid              (in_valid),
    .in_ready              (in_ready),
    .significand_1         (significand_1),
    .shifted_significand_2 (shifted_significand_2),
    .exponent_1            (exponent_1),
    .sign_bit              (sign_bit),
    .num_1                 (num_1),
    .num_2                 (num_2),
    .out_valid             (out_valid),
    .out_ready             (out_ready),
    .result                (result),
    .overflow              (overflow),
    .zero                  (zero)
  );

  fp_mag_recover u_mag_tb (
    .significand_1         (tm_sig1),
    .shifted_significand_2 (tm_sh2),
    .eff_sub               (tm_sub),
    .mant                  (tm_mant)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Consumer handshake: random when enabled, otherwise the forced level.
  always @(posedge clk) begin
    #2;
    out_ready = bp_rand ? ($urandom_range(0, 3) != 0) : ready_force;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: latency on the rising edge of out_valid, payload on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_valid = 1'b0;
    end else begin
      if (out_valid && !prev_valid) begin
        if (sb.size() == 0) check("output_without_request", 32'(sb.size()), 32'd1);
        else check("latency", 32'(cyc - sb[0].acc), 32'(sb[0].lat));
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        check("result", result, e.res);
        check("overflow", 32'(overflow), 32'(e.ovf));
        check("zero", 32'(zero), 32'(e.zro));
      end
      prev_valid = out_valid;
    end
  end

  // Reference: exact integer arithmetic on the significands, then
  // normalization expressed through the leading-one position.
  function automatic exp_t model(input op_t op);
    exp_t r;
    longint unsigned m2, mag, sig1, e;
    int msb, s;
    bit esub;
    r.res = '0; r.ovf = 1'b0; r.zro = 1'b0; r.acc = 0; r.lat = 1;
    sig1 = longint'(op.sig1);
    esub = op.num_1[31] != op.num_2[31];
    m2   = esub ? ((64'h100_0000 - longint'(op.sh2)) % 64'h100_0000) : longint'(op.sh2);
    mag  = esub ? ((sig1 >= m2) ? sig1 - m2 : m2 - sig1) : sig1 + m2;
    e    = (op.exp1 == 8'd0) ? 1 : longint'(op.exp1);
    if (op.exp1 == 8'hFF) begin
      if (op.num_1[30:0] == 31'h7F80_0000 && op.num_2[30:0] == 31'h7F80_0000 && esub)
        r.res = 32'h7FC0_0000;
      else
        r.res = op.num_1;
    end else if (mag >= 64'h100_0000) begin
      e   = e + 1;
      mag = mag >> 1;
      if (e == 255) begin
        r.res = {op.sign, 8'hFF, 23'd0};
        r.ovf = 1'b1;
      end else begin
        r.res = {op.sign, e[7:0], mag[22:0]};
      end
    end else if (mag == 0) begin
      r.res = {~esub & op.sign, 31'd0};
      r.zro = 1'b1;
    end else begin
      msb = 0;
      for (int i = 0; i < 24; i++) if (mag[i]) msb = i;
      s = 23 - msb;
      if (longint'(s) > e - 1) s = int'(e - 1);
      mag   = mag << s;
      e     = e - longint'(s);
      r.res = {op.sign, mag[23] ? e[7:0] : 8'd0, mag[22:0]};
      r.lat = 1 + s;
    end
    return r;
  endfunction

  function automatic op_t mk_op(input logic [23:0] s1, input logic [23:0] s2,
                                input logic [7:0] ex, input logic sg,
                                input logic [31:0] n1, input logic [31:0] n2);
    op_t op;
    op.sig1 = s1; op.sh2 = s2; op.exp1 = ex; op.sign = sg; op.num_1 = n1; op.num_2 = n2;
    return op;
  endfunction

  function automatic exp_t mk_exp(input logic [31:0] res, input logic ovf,
                                  input logic zro, input int lat);
    exp_t e;
    e.res = res; e.ovf = ovf; e.zro = zro; e.acc = 0; e.lat = lat;
    return e;
  endfunction

  function automatic op_t rand_op();
    op_t op;
    int k;
    longint unsigned d, m2;
    bit esub;
    case ($urandom_range(0, 9))
      0:       op.exp1 = 8'd0;
      1:       op.exp1 = 8'hFF;
      2:       op.exp1 = 8'd254;
      3:       op.exp1 = 8'($urandom_range(1, 3));
      default: op.exp1 = 8'($urandom_range(1, 254));
    endcase
    op.sig1 = {op.exp1 != 8'd0, 23'($urandom)};
    if (op.exp1 == 8'hFF && $urandom_range(0, 1) == 1) op.sig1[22:0] = '0;
    op.num_1 = {1'($urandom), op.exp1, op.sig1[22:0]};
    if (op.exp1 == 8'hFF && $urandom_range(0, 1) == 1) op.num_2 = {1'($urandom), 8'hFF, 23'd0};
    else op.num_2 = $urandom;
    esub = op.num_1[31] ^ op.num_2[31];
    k = $urandom_range(0, 24);
    if ($urandom_range(0, 2) == 0) begin
      op.sh2 = 24'($urandom);
    end else if (esub) begin
      d  = (longint'($urandom) % (longint'(op.sig1) + 1)) >> k;
      m2 = longint'(op.sig1) - d;
      op.sh2 = 24'((64'h100_0000 - m2) % 64'h100_0000);
    end else begin
      op.sh2 = 24'($urandom) >> k;
    end
    op.sign = 1'($urandom);
    return op;
  endfunction

  task automatic send(input op_t op, input exp_t ex);
    int w;
    w = 0;
    while (!in_ready && w < 500) begin
      tick();
      w++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'(in_ready), 32'd1);
      return;
    end
    significand_1         = op.sig1;
    shifted_significand_2 = op.sh2;
    exponent_1            = op.exp1;
    sign_bit              = op.sign;
    num_1                 = op.num_1;
    num_2                 = op.num_2;
    in_valid              = 1'b1;
    tick();
    in_valid = 1'b0;
    ex.acc   = cyc;
    sb.push_back(ex);
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sb.size() != 0 && w < 1000) begin
      tick();
      w++;
    end
    check("drain", 32'(sb.size()), 32'd0);
  endtask

  op_t t1, t2, t3, t4a, t4b, tden;

  initial begin
    t1   = mk_op(24'h800000, 24'h800000, 8'd127, 1'b0, 32'h3F80_0000, 32'h3F80_0000);
    t2   = mk_op(24'h800000, 24'hA00000, 8'd127, 1'b0, 32'h3F80_0000, 32'hBF40_0000);
    t3   = mk_op(24'hFFFFFF, 24'hFFFFFF, 8'd254, 1'b0, 32'h7F7F_FFFF, 32'h7F7F_FFFF);
    t4a  = mk_op(24'h800000, 24'h800000, 8'd127, 1'b0, 32'h3F80_0000, 32'hBF80_0000);
    t4b  = mk_op(24'h800000, 24'h800000, 8'd255, 1'b0, 32'h7F80_0000, 32'hFF80_0000);
    tden = mk_op(24'h000010, 24'h000001, 8'd0,   1'b0, 32'h0000_0010, 32'h0000_0001);

    // Standalone magnitude recovery.
    for (int i = 0; i < 16; i++) begin
      longint unsigned a, b, m2, mag;
      tm_sig1 = 24'($urandom);
      tm_sh2  = (i < 2) ? tm_sig1 : 24'($urandom);
      tm_sub  = 1'(i % 2);
      #1;
      a   = longint'(tm_sig1);
      b   = longint'(tm_sh2);
      m2  = tm_sub ? ((64'h100_0000 - b) % 64'h100_0000) : b;
      mag = tm_sub ? ((a >= m2) ? a - m2 : m2 - a) : a + m2;
      check("mag_recover", 32'(tm_mant), 32'(mag));
    end

    // Reset state.
    rst_n = 1'b0;
    ready_force = 1'b1;
    repeat (3) tick();
    check("reset_in_ready", 32'(in_ready), 32'd0);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_result", result, 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    check("reset_zero", 32'(zero), 32'd0);
    rst_n = 1'b1;
    tick();

    // Directed corner cases.
    send(t1,   mk_exp(32'h4000_0000, 1'b0, 1'b0, 1));
    send(t2,   mk_exp(32'h3E80_0000, 1'b0, 1'b0, 3));
    send(t3,   mk_exp(32'h7F80_0000, 1'b1, 1'b0, 1));
    send(t4a,  mk_exp(32'h0000_0000, 1'b0, 1'b1, 1));
    send(t4b,  mk_exp(32'h7FC0_0000, 1'b0, 1'b0, 1));
    send(tden, mk_exp(32'h0000_0011, 1'b0, 1'b0, 1));
    drain();

    // Backpressure: result held, pulses on in_valid ignored.
    ready_force = 1'b0;
    tick();
    send(t1, mk_exp(32'h4000_0000, 1'b0, 1'b0, 1));
    for (int w = 0; w < 50 && !out_valid; w++) tick();
    check("bp_valid", 32'(out_valid), 32'd1);
    for (int k = 0; k < 5; k++) begin
      num_1         = 32'($urandom);
      significand_1 = 24'($urandom);
      in_valid      = 1'b1;
      tick();
      check("bp_result_held", result, 32'h4000_0000);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
    end
    in_valid    = 1'b0;
    ready_force = 1'b1;
    tick();
    tick();
    check("bp_consumed_valid", 32'(out_valid), 32'd0);
    check("bp_consumed_in_ready", 32'(in_ready), 32'd1);
    repeat (2) tick();
    check("bp_no_capture", 32'(out_valid), 32'd0);

    // Reset in the middle of normalization.
    send(t2, mk_exp(32'h3E80_0000, 1'b0, 1'b0, 3));
    rst_n = 1'b0;
    sb.delete();
    #1;
    check("rst_in_ready_low", 32'(in_ready), 32'd0);
    tick();
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    tick();
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    send(t1, mk_exp(32'h4000_0000, 1'b0, 1'b0, 1));
    drain();

    // Randomized traffic with random consumer stalls.
    bp_rand = 1'b1;
    for (int n = 0; n < 300; n++) begin
      op_t op;
      op = rand_op();
      send(op, model(op));
      if ($urandom_range(0, 7) == 0) tick();
    end
    drain();
    bp_rand = 1'b0;
    repeat (3) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
